// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: drives the instruction-memory read port, captures
// returned words into a small prefetch buffer, and hands them to decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1,
    parameter int          DEPTH       = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        InsMemRW,
    output logic [31:0] InsAddr,
    input  logic [31:0] IDataIn,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    output logic        InsValid,
    output logic [31:0] InsOut,
    output logic [31:0] InsPC,
    input  logic        InsReady,
    output logic        Fault
);

    // state   | meaning
    // S_IDLE  | first cycle after reset, no fetch issued yet
    // S_FETCH | read in flight, InsAddr held for MEM_LATENCY cycles
    // S_STALL | buffer full, waiting for decode to pop
    // S_HALT  | no new fetch; also the terminal state after a fault
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int             CW       = 4;
    localparam int             OW       = 3;
    localparam logic [CW-1:0]  LAST_CNT = CW'(MEM_LATENCY - 1);
    localparam logic [OW-1:0]  DEPTH_OW = OW'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_cnt;
    logic [OW-1:0] r_count;
    logic          r_fault;
    logic [31:0]   r_buf_ins [4];
    logic [31:0]   r_buf_pc  [4];

    logic          w_pop;
    logic          w_capture;
    logic          w_redirect;
    logic          w_misalign;
    logic          w_room;
    logic [OW-1:0] w_wr_pos;
    logic [OW-1:0] w_occ_after;

    assign w_pop       = (r_count != '0) && InsReady;
    assign w_capture   = (r_state == S_FETCH) && (r_cnt == LAST_CNT);
    assign w_redirect  = Redirect && !r_fault;
    assign w_misalign  = w_redirect && (RedirectPC[1:0] != 2'b00);
    // write slot is the occupancy left after this edge's pop
    assign w_wr_pos    = r_count - OW'(w_pop);
    assign w_occ_after = w_wr_pos + OW'(w_capture);
    assign w_room      = w_occ_after < DEPTH_OW;

    always_comb begin
        w_state_nxt = r_state;
        if (r_fault || w_misalign) begin
            w_state_nxt = S_HALT;
        end else if (w_redirect) begin
            w_state_nxt = Halt ? S_HALT : S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = Halt ? S_HALT : S_FETCH;
                S_FETCH: begin
                    if (w_capture) begin
                        if (Halt)        w_state_nxt = S_HALT;
                        else if (w_room) w_state_nxt = S_FETCH;
                        else             w_state_nxt = S_STALL;
                    end
                end
                S_STALL: begin
                    if (Halt)       w_state_nxt = S_HALT;
                    else if (w_pop) w_state_nxt = S_FETCH;
                end
                S_HALT: begin
                    if (!Halt) w_state_nxt = w_room ? S_FETCH : S_STALL;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_cnt      <= '0;
            r_count    <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_cnt   <= '0;
                r_count <= '0;
                if (w_misalign) r_fault    <= 1'b1;
                else            r_fetch_pc <= RedirectPC;
            end else begin
                if (w_capture) begin
                    r_cnt      <= '0;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end else if (r_state == S_FETCH) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                r_count <= w_occ_after;
            end
        end
    end

    // Shift-register buffer with the head in slot 0; stale slots are masked by r_count.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (w_capture && (w_wr_pos == OW'(i))) begin
                r_buf_ins[i] <= IDataIn;
                r_buf_pc[i]  <= r_fetch_pc;
            end else if (w_pop) begin
                r_buf_ins[i] <= r_buf_ins[i+1];
                r_buf_pc[i]  <= r_buf_pc[i+1];
            end
        end
        if (w_capture && (w_wr_pos == OW'(3))) begin
            r_buf_ins[3] <= IDataIn;
            r_buf_pc[3]  <= r_fetch_pc;
        end else if (w_pop) begin
            r_buf_ins[3] <= '0;
            r_buf_pc[3]  <= '0;
        end
    end

    assign InsMemRW = (r_state == S_FETCH);
    assign InsAddr  = r_fetch_pc;
    assign InsValid = (r_count != '0);
    assign InsOut   = InsValid ? r_buf_ins[0] : '0;
    assign InsPC    = InsValid ? r_buf_pc[0]  : '0;
    assign Fault    = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed tables on three parameterisations plus
// randomized traffic on the first one against a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;
    localparam int          A_ML    = 2;
    localparam int          A_DEPTH = 2;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          halt;
        bit          redir;
        logic [31:0] rpc;
        bit          rw;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        bit          flt;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // instance A: ML=2, DEPTH=2, RESET_PC=0
    logic a_rst = 0, a_redir = 0, a_halt = 0, a_rdy = 0;
    logic [31:0] a_rpc = 0;
    logic a_rw, a_valid, a_fault;
    logic [31:0] a_addr, a_ins, a_pc, a_idata;
    assign a_idata = a_addr ^ XOR_PAT;

    instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(A_ML), .DEPTH(A_DEPTH)) u_a (
        .CLK(CLK), .Reset(a_rst), .InsMemRW(a_rw), .InsAddr(a_addr), .IDataIn(a_idata),
        .Redirect(a_redir), .RedirectPC(a_rpc), .Halt(a_halt), .InsValid(a_valid),
        .InsOut(a_ins), .InsPC(a_pc), .InsReady(a_rdy), .Fault(a_fault));

    // instance B: ML=3, DEPTH=2
    logic b_rst = 0, b_redir = 0, b_halt = 0, b_rdy = 0;
    logic [31:0] b_rpc = 0;
    logic b_rw, b_valid, b_fault;
    logic [31:0] b_addr, b_ins, b_pc, b_idata;
    assign b_idata = b_addr ^ XOR_PAT;

    instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(3), .DEPTH(2)) u_b (
        .CLK(CLK), .Reset(b_rst), .InsMemRW(b_rw), .InsAddr(b_addr), .IDataIn(b_idata),
        .Redirect(b_redir), .RedirectPC(b_rpc), .Halt(b_halt), .InsValid(b_valid),
        .InsOut(b_ins), .InsPC(b_pc), .InsReady(b_rdy), .Fault(b_fault));

    // instance C: ML=1, DEPTH=2, start just below the address wrap
    logic c_rst = 0, c_redir = 0, c_halt = 0, c_rdy = 0;
    logic [31:0] c_rpc = 0;
    logic c_rw, c_valid, c_fault;
    logic [31:0] c_addr, c_ins, c_pc, c_idata;
    assign c_idata = c_addr ^ XOR_PAT;

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MEM_LATENCY(1), .DEPTH(2)) u_c (
        .CLK(CLK), .Reset(c_rst), .InsMemRW(c_rw), .InsAddr(c_addr), .IDataIn(c_idata),
        .Redirect(c_redir), .RedirectPC(c_rpc), .Halt(c_halt), .InsValid(c_valid),
        .InsOut(c_ins), .InsPC(c_pc), .InsReady(c_rdy), .Fault(c_fault));

    function automatic vec_t mk(bit rst, bit rdy, bit halt, bit redir, logic [31:0] rpc,
                                bit rw, logic [31:0] addr, bit v, logic [31:0] pc, bit flt);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.halt = halt; t.redir = redir; t.rpc = rpc;
        t.rw = rw; t.addr = addr; t.v = v; t.pc = pc; t.flt = flt;
        return t;
    endfunction

    task automatic apply(input int which, input vec_t t);
        case (which)
            0: begin a_rst = t.rst; a_rdy = t.rdy; a_halt = t.halt; a_redir = t.redir; a_rpc = t.rpc; end
            1: begin b_rst = t.rst; b_rdy = t.rdy; b_halt = t.halt; b_redir = t.redir; b_rpc = t.rpc; end
            default: begin c_rst = t.rst; c_rdy = t.rdy; c_halt = t.halt; c_redir = t.redir; c_rpc = t.rpc; end
        endcase
    endtask

    task automatic sample(input int which, output bit rw, output logic [31:0] addr, output bit v,
                          output logic [31:0] pc, output logic [31:0] ins, output bit flt);
        case (which)
            0: begin rw = a_rw; addr = a_addr; v = a_valid; pc = a_pc; ins = a_ins; flt = a_fault; end
            1: begin rw = b_rw; addr = b_addr; v = b_valid; pc = b_pc; ins = b_ins; flt = b_fault; end
            default: begin rw = c_rw; addr = c_addr; v = c_valid; pc = c_pc; ins = c_ins; flt = c_fault; end
        endcase
    endtask

    task automatic check(input string nm, input int which, input bit e_rw, input logic [31:0] e_addr,
                         input bit e_v, input logic [31:0] e_pc, input logic [31:0] e_ins, input bit e_flt);
        bit rw, v, flt;
        logic [31:0] addr, pc, ins;
        sample(which, rw, addr, v, pc, ins, flt);
        n_total++;
        if ({rw, addr, v, pc, ins, flt} !== {e_rw, e_addr, e_v, e_pc, e_ins, e_flt}) begin
            n_bad++;
            $display("FAIL %s: got rw=%0b addr=%h valid=%0b pc=%h ins=%h fault=%0b, want rw=%0b addr=%h valid=%0b pc=%h ins=%h fault=%0b",
                     nm, rw, addr, v, pc, ins, flt, e_rw, e_addr, e_v, e_pc, e_ins, e_flt);
        end
    endtask

    task automatic run_table(input int which, input string nm, input vec_t tbl[$]);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(which, tbl[i]);
            @(posedge CLK);
            #1;
            check($sformatf("%s[%0d]", nm, i), which, tbl[i].rw, tbl[i].addr, tbl[i].v, tbl[i].pc,
                  tbl[i].v ? (tbl[i].pc ^ XOR_PAT) : 32'h0, tbl[i].flt);
        end
    endtask

    // Reference model: a queue of {word, pc}, the fetch PC, and whether a read is
    // outstanding and how long it has been waiting.
    logic [63:0] m_q[$];
    logic [31:0] m_fpc = 32'h0;
    bit          m_inflight = 0;
    int          m_elapsed = 0;
    bit          m_fault = 0;

    task automatic model_step(input bit rst, input bit redir, input logic [31:0] rpc,
                              input bit halt, input bit ready);
        bit pop;
        bit mid;
        if (!rst) begin
            m_q.delete();
            m_fpc = 32'h0; m_inflight = 0; m_elapsed = 0; m_fault = 0;
        end else if (m_fault) begin
            // frozen until reset
        end else if (redir) begin
            m_q.delete();
            m_elapsed = 0;
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1; m_inflight = 0;
            end else begin
                m_fpc = rpc; m_inflight = !halt;
            end
        end else begin
            pop = (m_q.size() > 0) && ready;
            mid = m_inflight && (m_elapsed + 1 < A_ML);
            if (pop) void'(m_q.pop_front());
            if (mid) begin
                m_elapsed++;
            end else begin
                if (m_inflight) begin
                    m_q.push_back({m_fpc ^ XOR_PAT, m_fpc});
                    m_fpc = m_fpc + 32'd4;
                    m_elapsed = 0;
                end
                m_inflight = !halt && (m_q.size() < A_DEPTH);
            end
        end
    endtask

    initial begin
        vec_t ta[$];
        vec_t tb[$];
        vec_t tc[$];
        bit   halt_l;
        bit   rst_i, redir_i, rdy_i;
        logic [31:0] rpc_i;
        vec_t rv;

        // A: startup with InsReady=1
        ta.push_back(mk(0,1,0,0,0, 0,32'h00,0,32'h00,0));
        ta.push_back(mk(0,1,0,0,0, 0,32'h00,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h00,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h00,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h04,1,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h04,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h08,1,32'h04,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h08,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h0C,1,32'h08,0));
        // A: backpressure, then a single-cycle pop
        ta.push_back(mk(0,0,0,0,0, 0,32'h00,0,32'h00,0));
        ta.push_back(mk(1,0,0,0,0, 1,32'h00,0,32'h00,0));
        ta.push_back(mk(1,0,0,0,0, 1,32'h00,0,32'h00,0));
        ta.push_back(mk(1,0,0,0,0, 1,32'h04,1,32'h00,0));
        ta.push_back(mk(1,0,0,0,0, 1,32'h04,1,32'h00,0));
        ta.push_back(mk(1,0,0,0,0, 0,32'h08,1,32'h00,0));
        ta.push_back(mk(1,0,0,0,0, 0,32'h08,1,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h08,1,32'h04,0));
        ta.push_back(mk(1,0,0,0,0, 1,32'h08,1,32'h04,0));
        ta.push_back(mk(1,0,0,0,0, 0,32'h0C,1,32'h04,0));
        // A: Halt during the wait for 0x10, resume at 0x14
        ta.push_back(mk(0,1,0,0,0, 0,32'h00,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h00,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h00,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h04,1,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h04,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h08,1,32'h04,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h08,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h0C,1,32'h08,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h0C,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h10,1,32'h0C,0));
        ta.push_back(mk(1,1,1,0,0, 1,32'h10,0,32'h00,0));
        ta.push_back(mk(1,1,1,0,0, 0,32'h14,1,32'h10,0));
        ta.push_back(mk(1,1,1,0,0, 0,32'h14,0,32'h00,0));
        ta.push_back(mk(1,1,1,0,0, 0,32'h14,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h14,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h14,0,32'h00,0));
        ta.push_back(mk(1,1,0,0,0, 1,32'h18,1,32'h14,0));
        // A: misaligned redirect is sticky until reset, Halt ignored
        ta.push_back(mk(1,1,0,1,32'h102, 0,32'h18,0,32'h00,1));
        ta.push_back(mk(1,1,0,0,0,       0,32'h18,0,32'h00,1));
        ta.push_back(mk(1,1,1,0,0,       0,32'h18,0,32'h00,1));
        ta.push_back(mk(0,1,0,0,0,       0,32'h00,0,32'h00,0));

        // B: redirect in the 2nd wait cycle of fetch 8 (ML=3)
        tb.push_back(mk(0,1,0,0,0,      0,32'h00,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h00,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h00,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h00,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h04,1,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h04,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h04,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h08,1,32'h04,0));
        tb.push_back(mk(1,0,0,0,0,      1,32'h08,1,32'h04,0));
        tb.push_back(mk(1,0,0,1,32'h40, 1,32'h40,0,32'h00,0));
        tb.push_back(mk(1,0,0,0,0,      1,32'h40,0,32'h00,0));
        tb.push_back(mk(1,0,0,0,0,      1,32'h40,0,32'h00,0));
        tb.push_back(mk(1,0,0,0,0,      1,32'h44,1,32'h40,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h44,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h44,0,32'h00,0));
        tb.push_back(mk(1,1,0,0,0,      1,32'h48,1,32'h44,0));

        // C: address wrap and simultaneous push/pop at ML=1, then a full buffer
        tc.push_back(mk(0,1,0,0,0, 0,32'hFFFF_FFF8,0,32'h0,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'hFFFF_FFF8,0,32'h0,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'hFFFF_FFFC,1,32'hFFFF_FFF8,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'h0000_0000,1,32'hFFFF_FFFC,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'h0000_0004,1,32'h0000_0000,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'h0000_0008,1,32'h0000_0004,0));
        tc.push_back(mk(1,0,0,0,0, 0,32'h0000_000C,1,32'h0000_0004,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'h0000_000C,1,32'h0000_0008,0));
        tc.push_back(mk(1,1,0,0,0, 1,32'h0000_0010,1,32'h0000_000C,0));

        repeat (2) @(posedge CLK);
        #1;
        run_table(0, "startup_bp_halt_fault", ta);
        run_table(1, "redirect_ml3", tb);
        run_table(2, "wrap_ml1", tc);

        // Randomized traffic on A against the queue model.
        halt_l = 0;
        for (int k = 0; k < 3000; k++) begin
            rst_i = (k < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) halt_l = !halt_l;
            redir_i = ($urandom_range(0, 24) == 0);
            rpc_i = $urandom();
            if ($urandom_range(0, 39) != 0) rpc_i[1:0] = 2'b00;
            rdy_i = ($urandom_range(0, 3) != 0);
            rv = mk(rst_i, rdy_i, halt_l, redir_i, rpc_i, 0, 0, 0, 0, 0);
            apply(0, rv);
            @(posedge CLK);
            model_step(rst_i, redir_i, rpc_i, halt_l, rdy_i);
            #1;
            check($sformatf("random[%0d]", k), 0, m_inflight, m_fpc, m_q.size() > 0,
                  (m_q.size() > 0) ? m_q[0][31:0] : 32'h0,
                  (m_q.size() > 0) ? m_q[0][63:32] : 32'h0, m_fault);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
